// File: rtl/key_scan_arbiter.sv
// Shares one 20-bit debounce counter among NUM_KEYS active-low keys. A round-robin
// scanner grants it to one pressed key at a time and pulses key_flag once per press.
module key_scan_arbiter #(
  parameter int          NUM_KEYS  = 4,
  parameter int          IDX_W     = 2,
  parameter logic [19:0] COUNT_MAX = 20'd999_999
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic                busy,
  output logic [IDX_W-1:0]    grant_idx
);

  typedef enum logic {SCAN, DEBOUNCE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] flag_q, flag_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [19:0]         count_q, count_d;
  logic [NUM_KEYS-1:0] key_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  assign key_s = sync2_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      state_q <= SCAN;
      ptr_q   <= '0;
      grant_q <= '0;
      count_q <= '0;
      held_q  <= '0;
      flag_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      count_q <= count_d;
      held_q  <= held_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    count_d = count_q;
    // A released key re-arms in every state; a completed debounce may set it again below.
    held_d  = held_q & ~key_s;
    flag_d  = '0;
    case (state_q)
      SCAN: begin
        if (!key_s[ptr_q] && !held_q[ptr_q]) begin
          state_d = DEBOUNCE;
          grant_d = ptr_q;
          count_d = '0;
        end else begin
          ptr_d = wrap_inc(ptr_q);
        end
      end
      DEBOUNCE: begin
        // Resuming the scan past the granted key keeps service round-robin fair.
        if (key_s[grant_q]) begin
          count_d = '0;
          ptr_d   = wrap_inc(grant_q);
          state_d = SCAN;
        end else if (count_q == COUNT_MAX - 20'd1) begin
          flag_d[grant_q] = 1'b1;
          held_d[grant_q] = 1'b1;
          count_d         = '0;
          ptr_d           = wrap_inc(grant_q);
          state_d         = SCAN;
        end else begin
          count_d = count_q + 20'd1;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign key_flag  = flag_q;
  assign busy      = (state_q == DEBOUNCE);
  assign grant_idx = busy ? grant_q : ptr_q;

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter (4 keys, COUNT_MAX=10): a cycle-accurate vector
// table followed by hand-written sequences checked against a log of flag pulses.
module tb_key_scan_arbiter;
  localparam int          NK = 4;
  localparam int          IW = 2;
  localparam logic [19:0] CM = 20'd10;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_flag;
  logic          busy;
  logic [IW-1:0] grant_idx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int            c;
    logic [NK-1:0] f;
  } ev_t;
  ev_t ev[$];

  typedef struct {
    logic [NK-1:0] k;
    logic          rst_n;
    int            n;
    logic [NK-1:0] f;
    logic          b;
    logic [IW-1:0] g;
  } vec_t;
  vec_t vt[13];

  key_scan_arbiter #(.NUM_KEYS(NK), .IDX_W(IW), .COUNT_MAX(CM)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in(key_in),
    .key_flag(key_flag),
    .busy(busy),
    .grant_idx(grant_idx)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk)
    if (key_flag != '0) ev.push_back('{cyc, key_flag});

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ptr(input logic [IW-1:0] p, input string nm);
    int k = 0;
    while (!(busy == 1'b0 && grant_idx == p) && k < 50) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(k < 50), 32'd1);
  endtask

  task automatic wait_busy(input string nm);
    int k = 0;
    while (busy !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(k < 50), 32'd1);
  endtask

  initial begin
    int mark;
    int t0;
    int b;

    //        key    rst   n   flag   busy  grant
    vt[0]  = '{4'hF, 1'b0, 3,  4'h0, 1'b0, 2'd0};  // reset state
    vt[1]  = '{4'hE, 1'b1, 1,  4'h0, 1'b0, 2'd1};  // scanning, key 0 not yet synced
    vt[2]  = '{4'hE, 1'b1, 3,  4'h0, 1'b0, 2'd0};
    vt[3]  = '{4'hE, 1'b1, 1,  4'h0, 1'b1, 2'd0};  // granted
    vt[4]  = '{4'hE, 1'b1, 9,  4'h0, 1'b1, 2'd0};  // count 9, still counting
    vt[5]  = '{4'hE, 1'b1, 1,  4'h1, 1'b0, 2'd1};  // flag 10 cycles after busy
    vt[6]  = '{4'hE, 1'b1, 1,  4'h0, 1'b0, 2'd2};  // single-cycle pulse
    vt[7]  = '{4'hE, 1'b1, 30, 4'h0, 1'b0, 2'd0};  // held: skipped, never re-granted
    vt[8]  = '{4'hF, 1'b1, 1,  4'h0, 1'b0, 2'd1};  // release one cycle
    vt[9]  = '{4'hE, 1'b1, 4,  4'h0, 1'b1, 2'd0};  // re-armed, granted again
    vt[10] = '{4'hE, 1'b1, 9,  4'h0, 1'b1, 2'd0};
    vt[11] = '{4'hE, 1'b1, 1,  4'h1, 1'b0, 2'd1};  // second press flagged
    vt[12] = '{4'hF, 1'b1, 3,  4'h0, 1'b0, 2'd0};

    for (int i = 0; i < 13; i++) begin
      key_in    = vt[i].k;
      sys_rst_n = vt[i].rst_n;
      tick(vt[i].n);
      chk($sformatf("vec%0d flag", i), 32'(key_flag), 32'(vt[i].f));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("vec%0d grant", i), 32'(grant_idx), 32'(vt[i].g));
    end
    chk("vec pulse count", 32'(ev.size()), 32'd2);
    for (int i = 0; i < ev.size(); i++) chk("vec pulse value", 32'(ev[i].f), 32'h1);

    // Key 2: 6-cycle bounce aborts, then a stable 20-cycle press flags once.
    mark = ev.size();
    key_in = 4'b1011;
    tick(6);
    key_in = 4'hF;
    tick(1);
    key_in = 4'b1011;
    t0 = cyc;
    tick(20);
    key_in = 4'hF;
    tick(10);
    chk("bounce pulse count", 32'(ev.size() - mark), 32'd1);
    if (ev.size() > mark) begin
      chk("bounce pulse value", 32'(ev[mark].f), 32'h4);
      chk("bounce pulse window", 32'(ev[mark].c >= t0 + 13 && ev[mark].c <= t0 + 16), 32'd1);
    end

    // Keys 1 and 3 together: served 1 then 3, never in the same cycle.
    wait_ptr(2'd3, "wait ptr3");
    key_in = 4'b0101;
    mark = ev.size();
    tick(40);
    key_in = 4'hF;
    tick(5);
    chk("pair pulse count", 32'(ev.size() - mark), 32'd2);
    if (ev.size() >= mark + 2) begin
      chk("pair first", 32'(ev[mark].f), 32'h2);
      chk("pair second", 32'(ev[mark+1].f), 32'h8);
      chk("pair gap", 32'(ev[mark+1].c - ev[mark].c <= 14), 32'd1);
    end

    // Reset at count 5 of key 3: no pulse, then a full fresh debounce.
    wait_ptr(2'd1, "wait ptr1");
    key_in = 4'b0111;
    mark = ev.size();
    wait_busy("rst grant");
    tick(5);
    chk("rst pre busy", 32'(busy), 32'd1);
    chk("rst pre grant", 32'(grant_idx), 32'd3);
    sys_rst_n = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst flag", 32'(key_flag), 32'd0);
    chk("rst grant", 32'(grant_idx), 32'd0);
    wait_busy("rst regrant");
    b = cyc;
    chk("rst regrant idx", 32'(grant_idx), 32'd3);
    tick(10);
    chk("rst late flag", 32'(key_flag), 32'h8);
    key_in = 4'hF;
    tick(5);
    chk("rst pulse count", 32'(ev.size() - mark), 32'd1);
    if (ev.size() > mark) chk("rst pulse cycle", 32'(ev[mark].c - b), 32'd10);

    // All keys held 200 cycles: each flags exactly once, in order 0..3.
    wait_ptr(2'd2, "wait ptr2");
    key_in = 4'h0;
    mark = ev.size();
    tick(200);
    key_in = 4'hF;
    tick(5);
    chk("all pulse count", 32'(ev.size() - mark), 32'd4);
    if (ev.size() >= mark + 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("all order %0d", i), 32'(ev[mark+i].f), 32'(1) << i);
        if (i > 0) chk($sformatf("all gap %0d", i), 32'(ev[mark+i].c - ev[mark+i-1].c), 32'd11);
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_scan_arbiter.md
Name: key_scan_arbiter

Overview:
- Shares one debounce counter among NUM_KEYS active-low mechanical keys.
- A round-robin scanner grants the counter to one pressed key at a time.
- After COUNT_MAX consecutive stable-low cycles, the block emits a one-cycle flag for that key.
- Sits between board key pins and the application FSMs; replaces one 20-bit debounce counter per key.

Parameters:
- NUM_KEYS, 4, number of keys, 2..8.
- IDX_W, 2, index width, ceil(log2(NUM_KEYS)).
- COUNT_MAX, 20'd999_999, stable-low cycles required (20 ms at 50 MHz), ≥2.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset.
- key_in  input  NUM_KEYS  raw key pins, active-low, asynchronous.
- key_flag  output  NUM_KEYS  one-cycle pulse per debounced press.
- busy  output  1  high while the counter is granted (state DEBOUNCE).
- grant_idx  output  IDX_W  key currently owning or being examined by the counter.

Behaviour:
- One clock; reset is synchronous and active-low: sys_clk, sys_rst_n sampled on posedge only.
- Reset values:
  - key_flag=0, busy=0, grant_idx=0.
  - count=0, held=0, state=SCAN.
  - both synchronizer stages=all-ones (released).
- Synchronizer: 2-flop per key; key_s = second stage. All decisions use key_s only.
- held[i] is cleared on any cycle where key_s[i]==1, in every state.
- SCAN state, one key examined per cycle at pointer ptr:
  - key_s[ptr]==0 and held[ptr]==0: go to DEBOUNCE, grant=ptr, count<=0.
  - Otherwise: ptr<=ptr+1, wrapping NUM_KEYS-1 -> 0.
- DEBOUNCE state, checks evaluated in this order:
  - key_s[grant]==1: abort. No flag, count<=0, ptr<=grant+1 (wrapped), go to SCAN.
  - Else count==COUNT_MAX-1: key_flag[grant]<=1 for exactly one cycle, held[grant]<=1, count<=0, ptr<=grant+1, go to SCAN.
  - Else count<=count+1.
- Latency:
  - The flag rises COUNT_MAX cycles after the DEBOUNCE-entry edge.
  - Pin-to-flag is 2 (sync) + scan wait (0..NUM_KEYS-1) + 1 + COUNT_MAX cycles.
- key_flag is one-hot or zero at all times. The flag bit deasserts the following cycle.
- A key held down fires once only; it re-arms after key_s goes high for at least one cycle.
  - A release bounce that then stays low COUNT_MAX cycles is a legal new press.
- Fairness: ptr advancing past the served or aborted key ensures any continuously pressed, un-held key is granted within NUM_KEYS-1 other services.
- Other keys pressed during DEBOUNCE are not lost: they are examined when SCAN resumes.
- Counter is 20 bits: no overflow, since it is cleared on completion.
- busy = (state==DEBOUNCE).
- grant_idx = grant in DEBOUNCE, ptr in SCAN.
- Reset mid-DEBOUNCE: all state returns to reset values next edge, with no flag pulse. Keys still low after reset need a full new debounce.

Test Plan:
- NUM_KEYS=4, COUNT_MAX=10, key_in[0] low from cycle 5 held 40 cycles, others high -> exactly one key_flag=4'b0001 pulse, 10 cycles after busy rises; no further pulse while held.
- key_in[2] low 6 cycles, high 1, low 20 -> first window aborts without a flag; exactly one key_flag=4'b0100 pulse after 10 stable cycles of the second press.
- key_in[1] and key_in[3] low simultaneously and held -> key_flag 4'b0010, then 4'b1000 ≤14 cycles later; never both bits in one cycle.
- key_in[0] pressed, flagged, released 1 cycle, pressed 15 cycles -> second 4'b0001 pulse; with no release, no second pulse.
- sys_rst_n low for 1 cycle at count=5 of key 3 -> busy=0, key_flag=0 next cycle; key 3 still low -> flag 10 cycles after re-grant.
- All four keys held constantly low for 200 cycles -> each bit pulses exactly once, in order 0,1,2,3.
